// File: rtl/crc_hex_display.sv
// crc_hex_display: double-buffered 4-digit hex seven-segment driver; LEADING_ZERO_BLANK_EN blanks leading zero digits
`timescale 1ns/1ps
module crc_hex_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] DATA_IN,
  input  logic        DATA_VALID,
  output logic        DATA_READY,
  output logic [3:0]  ANODES,
  output logic [6:0]  SEGMENTS,
  output logic        DP
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [111:0] HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                  7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [1:0]    next_idx;
  logic [15:0]   pending_reg;
  logic [15:0]   display_reg;
  logic [15:0]   eff;
  logic [3:0]    nib;
  logic          pending_full;
  logic          tick;
  logic          commit;
  logic          blank;
  assign tick       = prescaler == PW'(REFRESH_DIV - 1);
  assign commit     = tick && digit_idx == 2'd3 && pending_full;
  assign next_idx   = digit_idx + 2'd1;
  assign eff        = commit ? pending_reg : display_reg;
  assign nib        = eff[{next_idx, 2'b00} +: 4];
  assign DATA_READY = !pending_full;
  assign DP         = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;
  assign msd   = |eff[15:12] ? 2'd3 : |eff[11:8] ? 2'd2 : |eff[7:4] ? 2'd1 : 2'd0;
  assign blank = next_idx > msd;
`else
  assign blank = 1'b0;
`endif
  // digit slot timer: prescaler wraps on tick, which advances the scanned digit
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      prescaler <= '0;
      digit_idx <= 2'd3;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) digit_idx <= next_idx;
    end
  // pending buffer captures on handshake and moves to the display at the frame boundary
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      pending_full <= 1'b0;
      pending_reg  <= '0;
      display_reg  <= '0;
    end else if (commit) begin
      display_reg  <= pending_reg;
      pending_full <= 1'b0;
    end else if (DATA_VALID && !pending_full) begin
      pending_reg  <= DATA_IN;
      pending_full <= 1'b1;
    end
  // registered digit drive, loaded only on tick so each digit holds for a full slot
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      ANODES   <= 4'hF;
      SEGMENTS <= 7'h7F;
    end else if (tick) begin
      ANODES   <= blank ? 4'hF : ~(4'b0001 << next_idx);
      SEGMENTS <= blank ? 7'h7F : HEX[nib*7 +: 7];
    end
endmodule
